// File: rtl/imuldiv_div_arbiter.sv
// Two-port arbiter in front of one shared iterative divider.
// It keeps a single transaction in flight: IDLE -> ISSUE -> WAIT -> RESP.
module imuldiv_div_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_msg_fn,
   input  logic [31:0] req0_msg_a,
   input  logic [31:0] req0_msg_b,
   input  logic        req0_val,
   output logic        req0_rdy,
   input  logic        req1_msg_fn,
   input  logic [31:0] req1_msg_a,
   input  logic [31:0] req1_msg_b,
   input  logic        req1_val,
   output logic        req1_rdy,
   output logic [63:0] resp0_msg_result,
   output logic        resp0_val,
   input  logic        resp0_rdy,
   output logic [63:0] resp1_msg_result,
   output logic        resp1_val,
   input  logic        resp1_rdy,
   output logic        divreq_msg_fn,
   output logic [31:0] divreq_msg_a,
   output logic [31:0] divreq_msg_b,
   output logic        divreq_val,
   input  logic        divreq_rdy,
   input  logic [63:0] divresp_msg_result,
   input  logic        divresp_val,
   output logic        divresp_rdy,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic        fn_q, fn_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] result_q, result_d;

   logic        grant_val_s;
   logic        grant_idx_s;
   logic        resp_fire_s;

   // Grant selection. On a tie the round-robin mode favours the port that was not served last.
   always_comb begin
      grant_val_s = req0_val | req1_val;
      grant_idx_s = 1'b0;
      if (RR_EN) begin
         if (req0_val && req1_val) begin
            grant_idx_s = ~last_owner_q;
         end else begin
            grant_idx_s = req1_val;
         end
      end else begin
         grant_idx_s = ~req0_val;
      end
   end

   assign resp_fire_s = owner_q ? resp1_rdy : resp0_rdy;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         fn_q         <= 1'b0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         result_q     <= 64'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         fn_q         <= fn_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
      end
   end

   // Next-state logic. Latched data only moves on the handshake that owns it.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      fn_d         = fn_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_val_s) begin
               state_d = ST_ISSUE;
               owner_d = grant_idx_s;
               fn_d    = grant_idx_s ? req1_msg_fn : req0_msg_fn;
               a_d     = grant_idx_s ? req1_msg_a  : req0_msg_a;
               b_d     = grant_idx_s ? req1_msg_b  : req0_msg_b;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (divreq_rdy) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (divresp_val) begin
               state_d  = ST_RESP;
               result_d = divresp_msg_result;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (resp_fire_s) begin
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the registered state. The IDLE grant is the only combinational path.
   always_comb begin
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      divreq_val  = 1'b0;
      divresp_rdy = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req0_rdy = grant_val_s & ~grant_idx_s;
            req1_rdy = grant_val_s &  grant_idx_s;
         end
         ST_ISSUE: begin
            divreq_val = 1'b1;
         end
         ST_WAIT: begin
            divresp_rdy = 1'b1;
         end
         ST_RESP: begin
            resp0_val = ~owner_q;
            resp1_val =  owner_q;
         end
         default: begin
            req0_rdy = 1'b0;
         end
      endcase
   end

   assign divreq_msg_fn    = fn_q;
   assign divreq_msg_a     = a_q;
   assign divreq_msg_b     = b_q;
   assign resp0_msg_result = result_q;
   assign resp1_msg_result = result_q;
   assign busy             = (state_q != ST_IDLE);
   assign owner            = owner_q;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Directed bench: a round-robin arbiter and a fixed-priority arbiter run side by side on the same stimulus.
module tb_imuldiv_div_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_msg_fn, req1_msg_fn;
   logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
   logic        req0_val, req1_val;
   logic        resp0_rdy, resp1_rdy;
   logic        divreq_rdy, divresp_val;
   logic [63:0] divresp_msg_result;

   logic        req0_rdy, req1_rdy, resp0_val, resp1_val;
   logic [63:0] resp0_msg_result, resp1_msg_result;
   logic        divreq_msg_fn, divreq_val, divresp_rdy, busy, owner;
   logic [31:0] divreq_msg_a, divreq_msg_b;

   logic        f_req0_rdy, f_req1_rdy, f_resp0_val, f_resp1_val;
   logic [63:0] f_resp0_msg_result, f_resp1_msg_result;
   logic        f_divreq_msg_fn, f_divreq_val, f_divresp_rdy, f_busy, f_owner;
   logic [31:0] f_divreq_msg_a, f_divreq_msg_b;

   int errors = 0;
   int checks = 0;
   logic exp_owner;

   always #5 clk = ~clk;

   imuldiv_div_arbiter #(.RR_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
      .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
      .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
      .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
      .busy(busy), .owner(owner)
   );

   imuldiv_div_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
      .req0_val(req0_val), .req0_rdy(f_req0_rdy),
      .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
      .req1_val(req1_val), .req1_rdy(f_req1_rdy),
      .resp0_msg_result(f_resp0_msg_result), .resp0_val(f_resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg_result(f_resp1_msg_result), .resp1_val(f_resp1_val), .resp1_rdy(resp1_rdy),
      .divreq_msg_fn(f_divreq_msg_fn), .divreq_msg_a(f_divreq_msg_a), .divreq_msg_b(f_divreq_msg_b),
      .divreq_val(f_divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(f_divresp_rdy),
      .busy(f_busy), .owner(f_owner)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      req0_msg_fn = 1'b0; req0_msg_a = 32'd0; req0_msg_b = 32'd0; req0_val = 1'b0;
      req1_msg_fn = 1'b0; req1_msg_a = 32'd0; req1_msg_b = 32'd0; req1_val = 1'b0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0;
      divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'd0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b0);
      chk("rst_divreq_val", divreq_val, 1'b0);
      chk("rst_divresp_rdy", divresp_rdy, 1'b0);
      chk("rst_resp_vals", {resp1_val, resp0_val}, 2'b00);
      chk("rst_req_rdys", {req1_rdy, req0_rdy}, 2'b00);
      chk("rst_result", resp0_msg_result, 64'd0);
      chk("rst_divreq_a", divreq_msg_a, 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // Single request on port 0: 100 / 7
      req0_val = 1'b1; req0_msg_fn = 1'b1; req0_msg_a = 32'd100; req0_msg_b = 32'd7;
      #1;
      chk("single_req0_rdy", req0_rdy, 1'b1);
      chk("single_req1_rdy", req1_rdy, 1'b0);
      tick();
      req0_val = 1'b0; req0_msg_a = 32'd0;
      #1;
      chk("single_busy", busy, 1'b1);
      chk("single_divreq_val", divreq_val, 1'b1);
      chk("single_divreq_msg", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {1'b1, 32'd100, 32'd7});
      chk("single_req0_rdy_busy", req0_rdy, 1'b0);
      divreq_rdy = 1'b1;
      tick();
      divreq_rdy = 1'b0;
      #1;
      chk("single_wait_divreq_val", divreq_val, 1'b0);
      chk("single_wait_divresp_rdy", divresp_rdy, 1'b1);
      divresp_val = 1'b1; divresp_msg_result = {32'd2, 32'd14};
      tick();
      divresp_val = 1'b0; divresp_msg_result = 64'd0;
      #1;
      chk("single_resp_vals", {resp1_val, resp0_val}, 2'b01);
      chk("single_result", resp0_msg_result, {32'd2, 32'd14});
      chk("single_divresp_rdy_off", divresp_rdy, 1'b0);
      resp0_rdy = 1'b1;
      tick();
      resp0_rdy = 1'b0;
      #1;
      chk("single_idle_busy", busy, 1'b0);
      chk("single_owner_hold", owner, 1'b0);

      // Tie from reset: round-robin alternates 0,1,0,1; fixed priority always picks 0
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req0_val = 1'b1; req0_msg_fn = 1'b0; req0_msg_a = 32'd50; req0_msg_b = 32'd5;
      req1_val = 1'b1; req1_msg_fn = 1'b0; req1_msg_a = 32'd81; req1_msg_b = 32'd9;
      for (int k = 0; k < 4; k++) begin
         exp_owner = k[0];
         #1;
         chk("tie_rr_req_rdys", {req1_rdy, req0_rdy}, exp_owner ? 2'b10 : 2'b01);
         chk("tie_fp_req_rdys", {f_req1_rdy, f_req0_rdy}, 2'b01);
         tick();
         chk("tie_rr_owner", owner, exp_owner);
         chk("tie_rr_divreq_a", divreq_msg_a, exp_owner ? 32'd81 : 32'd50);
         chk("tie_fp_owner", f_owner, 1'b0);
         chk("tie_fp_divreq_a", f_divreq_msg_a, 32'd50);
         divreq_rdy = 1'b1;
         tick();
         divreq_rdy = 1'b0;
         divresp_val = 1'b1; divresp_msg_result = {32'd7, 32'd100 + 32'(k)};
         tick();
         divresp_val = 1'b0;
         chk("tie_rr_resp_vals", {resp1_val, resp0_val}, exp_owner ? 2'b10 : 2'b01);
         chk("tie_rr_result", exp_owner ? resp1_msg_result : resp0_msg_result, {32'd7, 32'd100 + 32'(k)});
         chk("tie_fp_busy", f_busy, 1'b1);
         resp0_rdy = 1'b1; resp1_rdy = 1'b1;
         tick();
         resp0_rdy = 1'b0; resp1_rdy = 1'b0;
         chk("tie_idle_busy", busy, 1'b0);
      end
      req0_val = 1'b0; req1_val = 1'b0;

      // Backpressure on divider request and response, plus a stray divresp_val while in RESP
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req0_val = 1'b1; req0_msg_a = 32'd9; req0_msg_b = 32'd2;
      tick();
      req0_val = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_issue_val", divreq_val, 1'b1);
         chk("bp_issue_msg", {divreq_msg_a, divreq_msg_b}, {32'd9, 32'd2});
         chk("bp_issue_owner", owner, 1'b0);
         tick();
      end
      divreq_rdy = 1'b1;
      tick();
      divreq_rdy = 1'b0;
      divresp_val = 1'b1; divresp_msg_result = {32'd1, 32'd4};
      tick();
      divresp_msg_result = {32'hDEAD, 32'hBEEF};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_resp_val", {resp1_val, resp0_val}, 2'b01);
         chk("bp_resp_result", resp0_msg_result, {32'd1, 32'd4});
         chk("bp_resp_no_divreq", {divreq_val, divresp_rdy}, 2'b00);
         tick();
      end
      divresp_val = 1'b0;
      resp0_rdy = 1'b1;
      tick();
      resp0_rdy = 1'b0;
      chk("bp_done_busy", busy, 1'b0);
      tick();
      chk("bp_single_resp", {resp1_val, resp0_val}, 2'b00);

      // Asynchronous reset while waiting on the divider
      req0_val = 1'b1; req0_msg_a = 32'd1; req0_msg_b = 32'd1;
      tick();
      req0_val = 1'b0;
      divreq_rdy = 1'b1;
      tick();
      divreq_rdy = 1'b0;
      chk("arst_in_wait", divresp_rdy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_resp_vals", {resp1_val, resp0_val}, 2'b00);
      chk("arst_divresp_rdy", divresp_rdy, 1'b0);
      tick();
      reset = 1'b1;
      req1_val = 1'b1; req1_msg_fn = 1'b1; req1_msg_a = -32'sd20; req1_msg_b = 32'd3;
      #1;
      chk("arst_req1_rdy", {req1_rdy, req0_rdy}, 2'b10);
      tick();
      req1_val = 1'b0;
      chk("arst_owner", owner, 1'b1);
      chk("arst_divreq_msg", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {1'b1, 32'hFFFF_FFEC, 32'd3});
      divreq_rdy = 1'b1;
      tick();
      divreq_rdy = 1'b0;
      divresp_val = 1'b1; divresp_msg_result = {32'hFFFF_FFFE, 32'hFFFF_FFFA};
      tick();
      divresp_val = 1'b0;
      chk("arst_resp_vals_after", {resp1_val, resp0_val}, 2'b10);
      chk("arst_result", resp1_msg_result, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
      resp1_rdy = 1'b1;
      tick();
      resp1_rdy = 1'b0;
      chk("arst_done_busy", busy, 1'b0);

      // Spurious divider response in IDLE is ignored
      divresp_val = 1'b1; divresp_msg_result = {32'd55, 32'd66};
      tick();
      tick();
      chk("spur_busy", busy, 1'b0);
      chk("spur_resp_vals", {resp1_val, resp0_val}, 2'b00);
      chk("spur_divresp_rdy", divresp_rdy, 1'b0);
      chk("spur_result_hold", resp1_msg_result, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
      chk("spur_owner_hold", owner, 1'b1);
      divresp_val = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
